// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : program_loader_pkg
// Description : Shared types and constants for the program loader. Holds the
//               loader state encoding, the default instruction-memory
//               geometry and the halt word that terminates a program image.
// Revision    : 1.0 - initial release
// ============================================================================
package program_loader_pkg;

    // Default instruction-memory geometry (DEPTH must equal 2**AW)
    localparam int DEPTH_DEFAULT = 64;
    localparam int AW_DEFAULT    = 6;

    // An all-zero word ends the image; it is written to memory like any other
    localparam logic [31:0] HALT_WORD = 32'h0000_0000;

    // Byte-counter value of the last byte of a 32-bit word
    localparam logic [1:0] LAST_BYTE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage : program_loader_pkg
`default_nettype wire

// File: rtl/program_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_packer
// Description : Assembles four accepted bytes into a little-endian 32-bit
//               word. Holds the byte counter and the assembly register.
// Ports       : clk      - clock, rising edge
//               reset    - asynchronous active-low reset
//               i_clear  - synchronous clear of counter and word (new load)
//               i_accept - a byte is transferred this cycle
//               i_byte   - the byte being transferred
//               o_word   - assembled word (complete after the 4th accept)
//               o_last   - this cycle's accept completes a word
// Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_last
);

    logic [1:0]  r_byte_cnt;
    logic [31:0] r_word;

    // Shifting each new byte in at the top means the first byte of a group
    // of four ends up in [7:0] and the fourth in [31:24]. The counter is
    // 2 bits wide so it wraps from 3 back to 0 on its own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byte_cnt <= 2'd0;
            r_word     <= 32'd0;
        end else if (i_clear) begin
            r_byte_cnt <= 2'd0;
            r_word     <= 32'd0;
        end else if (i_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_word     <= {i_byte, r_word[31:8]};
        end
    end

    assign o_word = r_word;
    assign o_last = i_accept && (r_byte_cnt == LAST_BYTE);

endmodule : byte_packer
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Receives a program image as a byte stream, packs it into
//               32-bit words and writes them to instruction memory from
//               address 0 while holding the CPU in reset. A halt word ends
//               the load and releases the CPU; filling every address without
//               seeing a halt word flags an overflow.
// Ports       : clk, reset (async, active-low)
//               start                 - begins (or restarts) a load
//               in_valid/in_data/in_ready - byte-stream handshake
//               imem_we/imem_addr/imem_wdata - instruction-memory write port
//               cpu_reset             - holds the CPU while not DONE
//               busy/done/err_overflow - load status
//               word_count            - words written in the current load
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = AW_DEFAULT
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          err_overflow,
    output logic [AW:0]   word_count
);

    localparam logic [AW-1:0] C_LAST_INDEX = AW'(DEPTH - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_index;
    logic [AW:0]   r_word_count;

    logic          w_accept;
    logic          w_last_byte;
    logic          w_clear;
    logic          w_index_inc;
    logic          w_count_inc;
    logic [31:0]   w_word;

    // in_ready is decoded straight from the state register so the accept
    // path does not pass through the next-state block.
    assign in_ready = (r_state == ST_RECV);
    assign w_accept = in_valid && in_ready;

    byte_packer u_byte_packer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_clear),
        .i_accept (w_accept),
        .i_byte   (in_data),
        .o_word   (w_word),
        .o_last   (w_last_byte)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_index_inc  = 1'b0;
        w_count_inc  = 1'b0;
        imem_we      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        err_overflow = 1'b0;
        cpu_reset    = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RECV;
                    w_clear      = 1'b1;
                end
            end

            // start is deliberately not examined here or in WRITE
            ST_RECV: begin
                busy = 1'b1;
                if (w_last_byte) begin
                    w_state_next = ST_WRITE;
                end
            end

            ST_WRITE: begin
                busy        = 1'b1;
                imem_we     = 1'b1;
                w_count_inc = 1'b1;
                // Halt takes priority: a halt word in the last slot still
                // ends the load cleanly rather than flagging overflow.
                if (w_word == HALT_WORD) begin
                    w_state_next = ST_DONE;
                end else if (r_index == C_LAST_INDEX) begin
                    w_state_next = ST_ERR;
                end else begin
                    w_index_inc  = 1'b1;
                    w_state_next = ST_RECV;
                end
            end

            ST_DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
                if (start) begin
                    w_state_next = ST_RECV;
                    w_clear      = 1'b1;
                end
            end

            ST_ERR: begin
                err_overflow = 1'b1;
                if (start) begin
                    w_state_next = ST_RECV;
                    w_clear      = 1'b1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Word index and word counter. The index only advances on a non-final
    // write, so it stops at DEPTH-1 and never wraps.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_index      <= '0;
            r_word_count <= '0;
        end else if (w_clear) begin
            r_index      <= '0;
            r_word_count <= '0;
        end else begin
            if (w_index_inc) begin
                r_index <= r_index + 1'b1;
            end
            if (w_count_inc) begin
                r_word_count <= r_word_count + 1'b1;
            end
        end
    end

    // Write data is gated so the bus reads zero outside the write cycle
    assign imem_addr  = r_index;
    assign imem_wdata = imem_we ? w_word : 32'd0;
    assign word_count = r_word_count;

endmodule : program_loader
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Directed self-checking bench for program_loader. Inputs are
//               driven and outputs sampled on the falling clock edge; every
//               write strobe is logged for later comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          err_overflow;
    logic [AW:0]   word_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW-1:0] log_addr[$];
    logic [31:0]   log_data[$];

    program_loader #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .err_overflow (err_overflow),
        .word_count   (word_count)
    );

    always #5 clk = ~clk;

    // Each write cycle lasts one clock, so exactly one falling edge sees it
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            log_addr.push_back(imem_addr);
            log_data.push_back(imem_wdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present a byte and hold it until the loader takes it; returns on the
    // falling edge after the accepting rising edge with in_valid dropped.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("send_byte_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'hA5;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            if (gap) @(negedge clk);
        end
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && err_overflow !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk(tag, 64'(done), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},   64'(in_ready),     64'd0);
        chk({tag, "_imem_we"},    64'(imem_we),      64'd0);
        chk({tag, "_busy"},       64'(busy),         64'd0);
        chk({tag, "_done"},       64'(done),         64'd0);
        chk({tag, "_err"},        64'(err_overflow), 64'd0);
        chk({tag, "_addr"},       64'(imem_addr),    64'd0);
        chk({tag, "_wdata"},      64'(imem_wdata),   64'd0);
        chk({tag, "_word_count"}, 64'(word_count),   64'd0);
        chk({tag, "_cpu_reset"},  64'(cpu_reset),    64'd1);
    endtask

    task automatic check_std_load(input string tag);
        chk({tag, "_nwrites"}, 64'(log_addr.size()), 64'd2);
        if (log_addr.size() >= 2) begin
            chk({tag, "_addr0"}, 64'(log_addr[0]), 64'd0);
            chk({tag, "_data0"}, 64'(log_data[0]), 64'h0040_0293);
            chk({tag, "_addr1"}, 64'(log_addr[1]), 64'd1);
            chk({tag, "_data1"}, 64'(log_data[1]), 64'h0000_0000);
        end
        chk({tag, "_done"},       64'(done),       64'd1);
        chk({tag, "_cpu_reset"},  64'(cpu_reset),  64'd0);
        chk({tag, "_word_count"}, 64'(word_count), 64'd2);
        chk({tag, "_busy"},       64'(busy),       64'd0);
    endtask

    initial begin
        int bad;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // ---------------- reset state ----------------
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_wait_busy", 64'(busy), 64'd0);

        // ---------------- basic load with latency checks ----------------
        pulse_start();
        chk("load_busy",      64'(busy),      64'd1);
        chk("load_in_ready",  64'(in_ready),  64'd1);
        chk("load_cpu_reset", 64'(cpu_reset), 64'd1);
        send_word(32'h0040_0293, 1'b0);
        // First falling edge after the 4th accept: write cycle
        chk("lat_we",       64'(imem_we),    64'd1);
        chk("lat_ready_lo", 64'(in_ready),   64'd0);
        chk("lat_addr",     64'(imem_addr),  64'd0);
        chk("lat_wdata",    64'(imem_wdata), 64'h0040_0293);
        @(negedge clk);
        chk("lat_ready_hi", 64'(in_ready),   64'd1);
        chk("lat_we_lo",    64'(imem_we),    64'd0);
        chk("lat_count1",   64'(word_count), 64'd1);
        send_word(32'h0000_0000, 1'b0);
        wait_end("load_timeout");
        check_std_load("load");

        // ---------------- restart from DONE, with backpressure ----------------
        log_addr.delete();
        log_data.delete();
        pulse_start();
        chk("rst_done_done",  64'(done),       64'd0);
        chk("rst_done_cpu",   64'(cpu_reset),  64'd1);
        chk("rst_done_count", 64'(word_count), 64'd0);
        chk("rst_done_busy",  64'(busy),       64'd1);
        send_word(32'h0040_0293, 1'b1);
        send_word(32'h0000_0000, 1'b1);
        wait_end("bp_timeout");
        check_std_load("bp");

        // ---------------- start ignored during RECV ----------------
        log_addr.delete();
        log_data.delete();
        pulse_start();
        send_byte(8'h11);
        send_byte(8'h22);
        pulse_start();
        chk("recv_start_busy",  64'(busy),       64'd1);
        chk("recv_start_ready", 64'(in_ready),   64'd1);
        send_byte(8'h33);
        send_byte(8'h44);
        chk("recv_start_we",    64'(imem_we),    64'd1);
        chk("recv_start_addr",  64'(imem_addr),  64'd0);
        chk("recv_start_wdata", 64'(imem_wdata), 64'h4433_2211);
        @(negedge clk);
        send_word(32'h0000_0000, 1'b0);
        wait_end("recv_start_timeout");
        chk("recv_start_done",  64'(done),       64'd1);
        chk("recv_start_count", 64'(word_count), 64'd2);

        // ---------------- reset mid-load ----------------
        pulse_start();
        send_word(32'h0403_0201, 1'b0);
        send_byte(8'h05);
        send_byte(8'h06);
        log_addr.delete();
        log_data.delete();
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("midrst_idle_busy",   64'(busy),             64'd0);
        chk("midrst_idle_writes", 64'(log_addr.size()),  64'd0);
        pulse_start();
        send_word(32'h0040_0293, 1'b0);
        send_word(32'h0000_0000, 1'b0);
        wait_end("midrst_timeout");
        check_std_load("midrst_load");

        // ---------------- overflow: 64 non-halt words ----------------
        log_addr.delete();
        log_data.delete();
        pulse_start();
        for (int w = 0; w < DEPTH; w++) begin
            send_word(32'h0000_0013, 1'b0);
        end
        wait_end("ovf_timeout");
        chk("ovf_nwrites", 64'(log_addr.size()), 64'd64);
        bad = 0;
        for (int i = 0; i < log_addr.size(); i++) begin
            if (log_addr[i] !== AW'(i) || log_data[i] !== 32'h0000_0013) bad++;
        end
        chk("ovf_bad_writes", 64'(bad),          64'd0);
        chk("ovf_err",        64'(err_overflow), 64'd1);
        chk("ovf_cpu_reset",  64'(cpu_reset),    64'd1);
        chk("ovf_in_ready",   64'(in_ready),     64'd0);
        chk("ovf_done",       64'(done),         64'd0);
        chk("ovf_count",      64'(word_count),   64'd64);
        @(negedge clk);
        chk("ovf_stays_err",  64'(err_overflow), 64'd1);

        // ---------------- restart from ERR ----------------
        pulse_start();
        chk("rst_err_err",   64'(err_overflow), 64'd0);
        chk("rst_err_busy",  64'(busy),         64'd1);
        chk("rst_err_count", 64'(word_count),   64'd0);
        chk("rst_err_addr",  64'(imem_addr),    64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_program_loader
`default_nettype wire

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DEPTH, default 64, instruction-memory depth in 32-bit words.
REQ-002 Parameter AW, default 6, imem address width, where DEPTH SHALL equal 2**AW.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 reset  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  single-cycle pulse that begins a load.
REQ-006 in_valid  in  1  byte-stream valid.
REQ-007 in_data  in  8  byte-stream data.
REQ-008 in_ready  out  1  loader accepts a byte this cycle.
REQ-009 imem_we  out  1  instruction-memory write strobe.
REQ-010 imem_addr  out  AW  word address of the write.
REQ-011 imem_wdata  out  32  word to write.
REQ-012 cpu_reset  out  1  active-high reset that holds the CPU during loading.
REQ-013 busy  out  1  load in progress.
REQ-014 done  out  1  load complete and CPU released.
REQ-015 err_overflow  out  1  no halt word arrived within DEPTH words.
REQ-016 word_count  out  AW+1  number of words written in the current load.

Function
REQ-017 The FSM SHALL have states IDLE, RECV, WRITE, DONE and ERR.
REQ-018 The FSM SHALL move from IDLE to RECV on start, clearing the word index, byte counter and word_count.
REQ-019 A byte SHALL be accepted only when in_valid and in_ready are both 1; in_ready SHALL be 1 only in RECV.
REQ-020 Bytes SHALL pack little-endian: the first accepted byte goes to [7:0] and the fourth to [31:24].
REQ-021 On the cycle the fourth byte is accepted, the FSM SHALL move from RECV to WRITE.
REQ-022 In WRITE, for exactly one cycle, imem_we SHALL be 1, imem_addr SHALL equal the word index and imem_wdata SHALL equal the assembled word, and word_count SHALL increment.
REQ-023 The FSM SHALL leave WRITE as follows:
- word equal to the halt word 32'h00000000: go to DONE (the halt word is itself written);
- otherwise, index equal to DEPTH-1: go to ERR;
- otherwise: increment the index and return to RECV.
REQ-024 Latency: if the fourth byte is accepted at edge N, the imem_we cycle SHALL follow edge N and in_ready SHALL be high again after edge N+1.
REQ-025 cpu_reset SHALL be 1 in every state except DONE, and SHALL fall at the edge that enters DONE.
REQ-026 busy SHALL be 1 in RECV and WRITE; done SHALL be 1 only in DONE; err_overflow SHALL be 1 only in ERR.
REQ-027 start SHALL be ignored in RECV and WRITE.
REQ-028 start in DONE or ERR SHALL re-enter RECV, reassert cpu_reset and clear done, err_overflow, word_count, the index and the byte counter.
REQ-029 The byte counter SHALL wrap from 3 to 0; the index SHALL never wrap.
REQ-030 Gaps in in_valid SHALL only stall the loader and SHALL NOT corrupt partial words.

Reset
REQ-031 Asserting reset low SHALL immediately force the following, including mid-load:
- state IDLE;
- in_ready, imem_we, busy, done and err_overflow to 0;
- imem_addr, imem_wdata, word_count, the index and the byte counter to 0;
- cpu_reset to 1.
REQ-032 After reset release the block SHALL wait in IDLE for start, and any partial word SHALL be discarded.

Structure
REQ-033 A shared package SHALL hold the state enum, the DEPTH default and the HALT_WORD constant 32'h00000000.
REQ-034 One sub-module, byte_packer, SHALL hold the byte counter and the 32-bit shift/assembly register; the FSM, index and outputs SHALL live in program_loader.

Verification
REQ-035 The bench SHALL cover the following directed scenarios:
- Load: start, then bytes 93 02 40 00 00 00 00 00 -> writes addr0=0x00400293 and addr1=0x00000000, then done=1, cpu_reset=0, word_count=2.
- Backpressure: the same stream with in_valid low on alternate cycles -> identical writes, and no byte lost or duplicated.
- Overflow: 64 words of 0x00000013 -> 64 writes (addr 0..63), then err_overflow=1, cpu_reset=1, in_ready=0.
- Reset mid-load: reset asserted after 6 bytes -> outputs at reset values; after start, a fresh stream is written from addr0.
- start during RECV after 2 bytes -> ignored, and the next 2 bytes complete the word at addr0.
- Restart from DONE: start -> done=0, cpu_reset=1, word_count=0; a new stream overwrites from addr0.
